id_stage: RTL
=============

Name: id_stage

Overview:
- RV32I decode/issue stage sitting directly upstream of regfile.
- Decodes the fetched instruction and drives rs1/rs2 addresses to regfile, which reads combinationally.
- Captures operands (with writeback bypass), immediate and control into an ID/EX register.
- Per-register busy scoreboard stalls RAW/WAW hazards until writeback.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, architectural registers; x0 is hardwired zero.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, active-low.
- if_valid  in  1  fetch holds an instruction.
- if_ready  out  1  ID accepts this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  instruction PC.
- rs1  out  5  regfile read address 1 = if_instr[19:15].
- rs2  out  5  regfile read address 2 = if_instr[24:20].
- rs1_val  in  XLEN  regfile read data 1.
- rs2_val  in  XLEN  regfile read data 2.
- wb_write  in  1  writeback commits this cycle (same signal as the regfile write enable).
- wb_rd  in  5  writeback destination.
- wb_val  in  XLEN  writeback data.
- flush  in  1  kill ID and ID/EX contents (taken branch/jump).
- ex_valid  out  1  ID/EX register holds an instruction.
- ex_ready  in  1  EX consumes ID/EX this cycle.
- ex_pc  out  XLEN  registered PC.
- ex_op1  out  XLEN  registered rs1 operand.
- ex_op2  out  XLEN  registered rs2 operand.
- ex_imm  out  XLEN  sign-extended immediate.
- ex_rd  out  5  destination register.
- ex_ctrl  out  ctrl_t  alu_op, imm_sel, op2_is_imm, is_load, is_store, is_branch, is_jal, is_jalr, rd_write, funct3.
- ex_illegal  out  1  unsupported opcode.

Behaviour:
- Clock is i_clk; reset is i_rst, asynchronous active-low. During reset: ex_valid=0, all ex_* outputs=0, ex_illegal=0, busy[31:0]=0.
- Decode (combinational):
  - Opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (treated as nop).
  - Any other opcode: issue with ex_illegal=1 and rd_write=0.
  - use_rs1 / use_rs2 are derived per format.
- Immediates:
  - I: sext(instr[31:20]).
  - S: sext({[31:25],[11:7]}).
  - B: sext({[31],[7],[30:25],[11:8],0}).
  - U: {[31:12],12'b0}.
  - J: sext({[31],[19:12],[20],[30:21],0}).
- Operand bypass: if wb_write and wb_rd!=0 and wb_rd==rs1, op1=wb_val, else rs1_val; same rule for rs2. x0 reads as 0 regardless of port values.
- Scoreboard:
  - busy_eff[r] = busy[r] & ~(wb_write & wb_rd==r).
  - stall = if_valid & ((use_rs1 & busy_eff[rs1]) | (use_rs2 & busy_eff[rs2]) | (rd_write & rd!=0 & busy_eff[rd])).
- Handshake:
  - advance = ~ex_valid | ex_ready.
  - if_ready = advance & ~stall & ~flush.
  - issue = if_valid & if_ready.
- Per clock edge:
  - issue: load ID/EX with the decoded instruction, ex_valid=1.
  - else if advance: ex_valid=0 (bubble). Data fields need not change.
  - else: hold all ID/EX fields.
- Busy update on each edge:
  - Clear busy[wb_rd] when wb_write.
  - Set busy[rd] on issue with rd_write & rd!=0.
  - Set wins on the same register. This is reachable only when the clear came through busy_eff.
- busy[0] is always 0.
- Flush has priority over issue:
  - ex_valid=0 next cycle.
  - If ex_valid & ~ex_ready & ex_ctrl.rd_write, clear busy[ex_rd].
  - The writeback clear in the same cycle still applies.
- Latency: 1 cycle from accept to ex_valid. No combinational path from ex_ready to ID/EX data.

Decomposition:
- riscv_pkg holds:
  - Opcode constants (OPC_LUI … OPC_MISC).
  - imm_sel_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}.
  - alu_op_e {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B}.
  - struct ctrl_t.
- Sub-module id_decoder: purely combinational; instr -> ctrl_t, imm, use_rs1, use_rs2, illegal.
- id_stage holds the scoreboard, the bypass and the ID/EX register.

Test Plan:
- Reset mid-stream (i_rst low for 1 cycle while ex_valid=1) -> ex_valid=0, busy=0 immediately; first instruction after release accepted.
- addi x5,x0,7 (0x00700293), ex_ready=1 -> next cycle ex_valid=1, ex_rd=5, ex_imm=7, alu_op=ADD, op2_is_imm=1, busy[5]=1.
- add x6,x5,x5 immediately after, no writeback -> if_ready=0 and bubbles. Then wb_write=1, wb_rd=5, wb_val=7 -> accepted that cycle, ex_op1=ex_op2=7.
- sw x2,-4(x1) (0xFE20AE23) -> ex_imm=0xFFFFFFFC, is_store=1, rd_write=0, no busy bit set.
- ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* stable, if_ready=0. ex_ready=1 -> next instruction loaded.
- flush with ex_valid=1, ex_rd=5 pending and if_valid=1 -> next cycle ex_valid=0, busy[5]=0, fetched instruction not accepted. Opcode 0x0000007F -> ex_illegal=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, decode enums and the control bundle carried into EX.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
    typedef enum logic [3:0] {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B} alu_op_e;
    typedef struct packed {
        alu_op_e    alu_op;
        imm_sel_e   imm_sel;
        logic       op2_is_imm;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       rd_write;
        logic [2:0] funct3;
    } ctrl_t;
    function automatic alu_op_e alu_f3(logic [2:0] f3, logic alt);
        case (f3)
            3'd0:    return alt ? SUB : ADD;
            3'd1:    return SLL;
            3'd2:    return SLT;
            3'd3:    return SLTU;
            3'd4:    return XOR;
            3'd5:    return alt ? SRA : SRL;
            3'd6:    return OR;
            default: return AND;
        endcase
    endfunction
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: fetch, regfile read, writeback and ID/EX signals of the decode stage.
interface id_stage_if;
    import riscv_pkg::*;
    logic            if_valid, if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            wb_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_val;
    logic            flush;
    logic            ex_valid, ex_ready;
    logic [XLEN-1:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]      ex_rd;
    ctrl_t           ex_ctrl;
    logic            ex_illegal;
    modport master (
        output if_valid, if_instr, if_pc, rs1_val, rs2_val, wb_write, wb_rd, wb_val, flush, ex_ready,
        input  if_ready, rs1, rs2, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_ctrl, ex_illegal
    );
    modport slave (
        input  if_valid, if_instr, if_pc, rs1_val, rs2_val, wb_write, wb_rd, wb_val, flush, ex_ready,
        output if_ready, rs1, rs2, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_ctrl, ex_illegal
    );
endinterface

// File: rtl/id_decoder.sv
// id_decoder: combinational RV32I decode into control, immediate and register-use flags.
module id_decoder
    import riscv_pkg::*;
(
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic            use_rs1,
    output logic            use_rs2,
    output logic            illegal
);
    logic [2:0] f3;
    assign f3 = instr[14:12];
    always_comb begin
        ctrl = '0;
        ctrl.funct3 = f3;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_LUI:    begin ctrl.alu_op = PASS_B; ctrl.imm_sel = IMM_U; ctrl.op2_is_imm = 1'b1; ctrl.rd_write = 1'b1; end
            OPC_AUIPC:  begin ctrl.imm_sel = IMM_U; ctrl.op2_is_imm = 1'b1; ctrl.rd_write = 1'b1; end
            OPC_JAL:    begin ctrl.imm_sel = IMM_J; ctrl.is_jal = 1'b1; ctrl.rd_write = 1'b1; end
            OPC_JALR:   begin ctrl.is_jalr = 1'b1; ctrl.op2_is_imm = 1'b1; ctrl.rd_write = 1'b1; use_rs1 = 1'b1; end
            OPC_BRANCH: begin ctrl.alu_op = SUB; ctrl.imm_sel = IMM_B; ctrl.is_branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_LOAD:   begin ctrl.is_load = 1'b1; ctrl.op2_is_imm = 1'b1; ctrl.rd_write = 1'b1; use_rs1 = 1'b1; end
            OPC_STORE:  begin ctrl.imm_sel = IMM_S; ctrl.is_store = 1'b1; ctrl.op2_is_imm = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            // instr[30] is an immediate bit for OP-IMM except on right shifts
            OPC_OPIMM:  begin ctrl.alu_op = alu_f3(f3, instr[30] & (f3 == 3'd5)); ctrl.op2_is_imm = 1'b1; ctrl.rd_write = 1'b1; use_rs1 = 1'b1; end
            OPC_OP:     begin ctrl.alu_op = alu_f3(f3, instr[30]); ctrl.rd_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_MISC:   ;
            default:    illegal = 1'b1;
        endcase
    end
    assign imm = ctrl.imm_sel == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
               : ctrl.imm_sel == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
               : ctrl.imm_sel == IMM_U ? {instr[31:12], 12'b0}
               : ctrl.imm_sel == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
               : {{20{instr[31]}}, instr[31:20]};
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode/issue with writeback bypass, busy-register scoreboard and ID/EX register.
module id_stage
    import riscv_pkg::*;
(
    input logic       i_clk,
    input logic       i_rst,
    id_stage_if.slave bus
);
    ctrl_t           ctrl;
    logic [XLEN-1:0] imm, op1, op2;
    logic            use_rs1, use_rs2, illegal, stall, advance, issue;
    logic [4:0]      rd;
    logic [NREG-1:0] busy, busy_eff, wb_hit, set_m, kill_m;
    id_decoder u_dec (
        .instr   (bus.if_instr),
        .ctrl    (ctrl),
        .imm     (imm),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .illegal (illegal)
    );
    assign rd       = bus.if_instr[11:7];
    assign bus.rs1  = bus.if_instr[19:15];
    assign bus.rs2  = bus.if_instr[24:20];
    assign wb_hit   = bus.wb_write ? NREG'(1) << bus.wb_rd : '0;
    assign busy_eff = busy & ~wb_hit;
    assign op1 = bus.rs1 == 5'd0 ? '0 : (bus.wb_write && bus.wb_rd == bus.rs1) ? bus.wb_val : bus.rs1_val;
    assign op2 = bus.rs2 == 5'd0 ? '0 : (bus.wb_write && bus.wb_rd == bus.rs2) ? bus.wb_val : bus.rs2_val;
    assign stall = bus.if_valid & ((use_rs1 & busy_eff[bus.rs1]) | (use_rs2 & busy_eff[bus.rs2])
                 | (ctrl.rd_write & (rd != 5'd0) & busy_eff[rd]));
    assign advance      = ~bus.ex_valid | bus.ex_ready;
    assign bus.if_ready = advance & ~stall & ~bus.flush;
    assign issue        = bus.if_valid & bus.if_ready;
    assign set_m  = (issue & ctrl.rd_write & (rd != 5'd0)) ? NREG'(1) << rd : '0;
    // a flushed instruction stuck in ID/EX will never write back, so release its destination
    assign kill_m = (bus.flush & bus.ex_valid & ~bus.ex_ready & bus.ex_ctrl.rd_write) ? NREG'(1) << bus.ex_rd : '0;
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            busy           <= '0;
            bus.ex_valid   <= 1'b0;
            bus.ex_pc      <= '0;
            bus.ex_op1     <= '0;
            bus.ex_op2     <= '0;
            bus.ex_imm     <= '0;
            bus.ex_rd      <= '0;
            bus.ex_ctrl    <= '0;
            bus.ex_illegal <= 1'b0;
        end else begin
            busy <= ((busy_eff & ~kill_m) | set_m) & ~NREG'(1);
            if (issue) begin
                bus.ex_valid   <= 1'b1;
                bus.ex_pc      <= bus.if_pc;
                bus.ex_op1     <= op1;
                bus.ex_op2     <= op2;
                bus.ex_imm     <= imm;
                bus.ex_rd      <= rd;
                bus.ex_ctrl    <= ctrl;
                bus.ex_illegal <= illegal;
            end else if (advance | bus.flush) begin
                bus.ex_valid <= 1'b0;
            end
        end
    end
endmodule
